// File: rtl/space_pkg.sv
// space_pkg: shared types and screen geometry for the space invaders core.
//   enemy_shot_state_e : one-hot state of the enemy bullet FSM
//   *_c constants      : playfield borders, floor row and player ship rows
package space_pkg;

  typedef enum logic [3:0] {
    COOLDOWN = 4'b0001,
    ARMED    = 4'b0010,
    FLYING   = 4'b0100,
    HIT      = 4'b1000
  } enemy_shot_state_e;

  localparam logic [9:0] left_border_c  = 10'd9;
  localparam logic [9:0] right_border_c = 10'd629;
  localparam logic [9:0] floor_c        = 10'd470;
  localparam logic [9:0] player_top_c   = 10'd434;
  localparam logic [9:0] player_bot_c   = 10'd454;

endpackage

// File: rtl/counter.sv
// counter: generic loadable up/down counter.
//   clk_i, reset_i : clock, synchronous active-high reset (to reset_val_p)
//   load_i, val_i  : load val_i (highest priority)
//   up_i / down_i  : add / subtract step_p (up wins over down)
//   count_o        : present count
module counter #(
  parameter int unsigned            width_p     = 8,
  parameter logic [width_p-1:0]     reset_val_p = '0,
  parameter logic [width_p-1:0]     step_p      = width_p'(1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               up_i,
  input  logic               down_i,
  input  logic               load_i,
  input  logic [width_p-1:0] val_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i)     count_o <= reset_val_p;
    else if (load_i) count_o <= val_i;
    else if (up_i)   count_o <= count_o + step_p;
    else if (down_i) count_o <= count_o - step_p;
  end

endmodule

// File: rtl/enemy_shooter.sv
// enemy_shooter: launches one enemy bullet from the selected alien's gun,
// moves it down once per frame and pulses hit_player_o on contact with the
// player ship.
//   clk_i, reset_i          : clock, synchronous active-high reset
//   frame_i                 : one-cycle pulse per video frame
//   fire_i, gun_x_i, gun_y_i: fire request and gun position from the formation
//   player_left_i/right_i   : player horizontal extent
//   player_alive_i, pause_i : player status / game frozen
//   hit_player_o            : one-cycle hit pulse
//   bullet_o, bullet_*_o    : bullet visible flag and box
//   red_o, green_o, blue_o  : bullet colour
//   state_o                 : present FSM state (debug)
module enemy_shooter
  import space_pkg::*;
#(
  parameter logic [11:0] color_p      = {4'hF, 4'hF, 4'hF},
  parameter logic [9:0]  step_p       = 10'd4,
  parameter logic [5:0]  cooldown_p   = 6'd30,
  parameter logic [9:0]  floor_p      = floor_c,
  parameter logic [9:0]  player_top_p = player_top_c,
  parameter logic [9:0]  player_bot_p = player_bot_c
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       frame_i,
  input  logic       fire_i,
  input  logic [9:0] gun_x_i,
  input  logic [9:0] gun_y_i,
  input  logic [9:0] player_left_i,
  input  logic [9:0] player_right_i,
  input  logic       player_alive_i,
  input  logic       pause_i,
  output logic       hit_player_o,
  output logic       bullet_o,
  output logic [9:0] bullet_left_o,
  output logic [9:0] bullet_right_o,
  output logic [9:0] bullet_top_o,
  output logic [9:0] bullet_bot_o,
  output logic [3:0] red_o,
  output logic [3:0] green_o,
  output logic [3:0] blue_o,
  output logic [3:0] state_o
);

  enemy_shot_state_e state_q, state_n;

  logic [5:0] cd_count;
  logic       cd_done, cd_up, cd_load;
  logic [9:0] left_q, top, spawn_left;
  logic       fire_ok, spawn, move, overlap, at_floor;

  assign cd_done  = (cd_count == cooldown_p);
  assign cd_up    = (state_q == COOLDOWN) & frame_i & ~cd_done;
  assign cd_load  = (state_q == COOLDOWN) & cd_done;

  assign fire_ok    = fire_i & player_alive_i & ~pause_i;
  assign spawn      = (state_q == ARMED) & fire_ok;
  assign spawn_left = (gun_x_i < 10'd3) ? '0 : gun_x_i - 10'd3;

  assign bullet_left_o  = left_q;
  assign bullet_right_o = left_q + 10'd6;
  assign bullet_top_o   = top;
  assign bullet_bot_o   = top + 10'd10;

  assign overlap  = (bullet_bot_o >= player_top_p) & (top <= player_bot_p) &
                    (bullet_right_o > player_left_i) & (left_q < player_right_i);
  assign at_floor = (top >= floor_p);
  // Motion only when no higher-priority exit (pause, hit, floor) applies.
  assign move     = (state_q == FLYING) & frame_i & ~pause_i & ~overlap & ~at_floor;

  counter #(
    .width_p    (6),
    .reset_val_p(6'd0),
    .step_p     (6'd1)
  ) u_cooldown_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .up_i   (cd_up),
    .down_i (1'b0),
    .load_i (cd_load),
    .val_i  (6'd0),
    .count_o(cd_count)
  );

  counter #(
    .width_p    (10),
    .reset_val_p(10'd0),
    .step_p     (step_p)
  ) u_top_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .up_i   (move),
    .down_i (1'b0),
    .load_i (spawn),
    .val_i  (gun_y_i),
    .count_o(top)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i)    left_q <= '0;
    else if (spawn) left_q <= spawn_left;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= COOLDOWN;
    else         state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      COOLDOWN: if (cd_done) state_n = ARMED;
      ARMED:    if (fire_ok) state_n = FLYING;
      FLYING: begin
        if (pause_i)       state_n = COOLDOWN;
        else if (overlap)  state_n = HIT;
        else if (at_floor) state_n = COOLDOWN;
      end
      HIT:      state_n = COOLDOWN;
      default:  state_n = COOLDOWN;
    endcase
  end

  always_comb begin
    hit_player_o = (state_q == HIT);
    bullet_o     = (state_q == FLYING);
    state_o      = state_q;
    red_o        = color_p[11:8];
    green_o      = color_p[7:4];
    blue_o       = color_p[3:0];
  end

endmodule
